// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving one Montgomery multiplier
// Define MONT_EXP_FINAL_CONV_EN to add a final product by 1 that leaves the Montgomery domain.
module mont_exp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     exp_len,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH:0]       mm_result,
  input  logic                 mm_done,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FINISH,
`ifdef MONT_EXP_FINAL_CONV_EN
    CV_ISSUE, CV_WAIT,
`endif
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_WIDTH);

  state_t                 state;
  logic [LEN_W-1:0]       cnt;
  logic [EXP_WIDTH-1:0]   e_sh;
  logic [WIDTH-1:0]       x_reg;
  logic [WIDTH-1:0]       a_reg;
  logic [LEN_W-1:0]       len_c;
  logic [WIDTH-1:0]       res_lo;
  logic                   unused_res_msb;

  assign len_c          = (exp_len > EXP_W_L) ? EXP_W_L : exp_len;
  assign res_lo         = mm_result[WIDTH-1:0];
  assign unused_res_msb = mm_result[WIDTH];

  // The exponent is left-aligned at capture so the bit under scan is always the MSB.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      mm_start <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      a_reg    <= '0;
      x_reg    <= '0;
      e_sh     <= '0;
      cnt      <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_reg <= in_x;
          mm_m  <= in_m;
          e_sh  <= in_e << (EXP_W_L - len_c);
          cnt   <= len_c;
          a_reg <= in_r;
          busy  <= 1'b1;
          if (len_c == '0) begin
            state <= FINISH;
          end else begin
            state    <= SQ_ISSUE;
            mm_start <= 1'b1;
            mm_a     <= in_r;
            mm_b     <= in_r;
          end
        end
        SQ_ISSUE: state <= SQ_WAIT;
        SQ_WAIT: if (mm_done) begin
          a_reg <= res_lo;
          if (e_sh[EXP_WIDTH-1]) begin
            state    <= MUL_ISSUE;
            mm_start <= 1'b1;
            mm_a     <= res_lo;
            mm_b     <= x_reg;
          end else begin
            state <= NEXT;
          end
        end
        MUL_ISSUE: state <= MUL_WAIT;
        MUL_WAIT: if (mm_done) begin
          a_reg <= res_lo;
          state <= NEXT;
        end
        NEXT: begin
          cnt  <= cnt - LEN_W'(1);
          e_sh <= e_sh << 1;
          if (cnt != LEN_W'(1)) begin
            state    <= SQ_ISSUE;
            mm_start <= 1'b1;
            mm_a     <= a_reg;
            mm_b     <= a_reg;
          end else begin
            state <= FINISH;
          end
        end
`ifdef MONT_EXP_FINAL_CONV_EN
        FINISH: begin
          state    <= CV_ISSUE;
          mm_start <= 1'b1;
          mm_a     <= a_reg;
          mm_b     <= WIDTH'(1);
        end
        CV_ISSUE: state <= CV_WAIT;
        CV_WAIT: if (mm_done) begin
          a_reg  <= res_lo;
          result <= res_lo;
          done   <= 1'b1;
          state  <= DONE;
        end
`else
        FINISH: begin
          result <= a_reg;
          done   <= 1'b1;
          state  <= DONE;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - randomized self-checking bench for mont_exp_ctrl with a behavioural multiplier
module tb_mont_exp_ctrl;
  localparam int W  = 1024;
  localparam int EW = 1024;
  localparam int LW = 11;
`ifdef MONT_EXP_FINAL_CONV_EN
  localparam bit CONV = 1'b1;
`else
  localparam bit CONV = 1'b0;
`endif
  localparam int K_SQ = 0, K_MUL = 1, K_CV = 2;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [W-1:0]  in_x = '0, in_r = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] exp_len = '0;
  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_m, result;
  logic [W:0]    mm_result;
  logic          done, busy;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .exp_len(exp_len),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    logic [767:0] a_lo, w_lo;
    checks++;
    if (act !== want) begin
      errors++;
      a_lo = act[767:0];
      w_lo = want[767:0];
      $display("FAIL %s got=%0h want=%0h", name, a_lo, w_lo);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", name, act, want);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic logic [W-1:0] wv(input int unsigned v);
    return W'(v);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  // a*b*2^-W mod m, bit-serial
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int k = 0; k < W; k++) begin
      if (a[k]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {a, {W{1'b0}}} % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  // plain right-to-left x^e mod m over the low len exponent bits
  function automatic logic [W-1:0] powmod(input logic [W-1:0] x, input logic [EW-1:0] e,
                                          input int len, input logic [W-1:0] m);
    logic [W-1:0] r, b;
    r = wv(1) % m;
    b = x % m;
    for (int k = 0; k < len; k++) begin
      if (e[k]) r = mulmod(r, b, m);
      b = mulmod(b, b, m);
    end
    return r;
  endfunction

  // behavioural multiplier
  int dly_min = 3, dly_max = 20, rsp_cnt = 0;
  bit spur_en = 1'b0;
  logic [W-1:0] ra, rb, rm;
  initial begin
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(posedge clk); #2;
      mm_done = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mm_done = 1'b1;
          mm_result = {1'($urandom_range(1, 0)), mont(ra, rb, rm)};
        end
      end
      if (mm_start) begin
        ra = mm_a; rb = mm_b; rm = mm_m;
        rsp_cnt = $urandom_range(dly_max, dly_min);
        if (spur_en) begin
          mm_done = 1'b1;
          mm_result = {1'b1, rand_wide()};
        end
      end
    end
  end

  // reference model: product list from the exponent, spec-level issue gaps, A tracked per product
  int m_age = 0, m_gap = -1, m_kind = 0, n_pulses = 0, n_dones = 0;
  int m_ops[$];
  bit m_gap_done = 1'b0, m_busy = 1'b0, m_wait = 1'b0, m_ab_chk = 1'b1;
  logic [W-1:0] m_a = '0, m_x = '0, m_m = '0, m_ea = '0, m_eb = '0, m_mmm = '0, m_res = '0;

  always @(negedge clk) begin : cmp
    bit exp_issue, exp_done, was_busy;
    int len;
    m_age++;
    exp_issue = (m_gap >= 0) && !m_gap_done && (m_age == m_gap);
    exp_done  = (m_gap >= 0) && m_gap_done && (m_age == m_gap);
    was_busy  = m_busy;
    if (mm_start) n_pulses++;
    if (done) n_dones++;
    chk_b("busy", busy, m_busy);
    chk_b("mm_start", mm_start, exp_issue);
    chk_b("done", done, exp_done);
    if (exp_issue) begin
      if (m_ops.size() > 0) m_kind = m_ops.pop_front();
      m_ea = m_a;
      m_eb = (m_kind == K_SQ) ? m_a : (m_kind == K_MUL) ? m_x : wv(1);
      m_ab_chk = 1'b1;
      m_gap = -1;
    end
    if (exp_done) begin
      m_res = m_a;
      m_gap = -1;
    end
    if (m_ab_chk) begin
      chk("mm_a", mm_a, m_ea);
      chk("mm_b", mm_b, m_eb);
    end
    chk("mm_m", mm_m, m_mmm);
    chk("result", result, m_res);
    if (!resetn) begin
      m_busy = 1'b0; m_ops.delete(); m_gap = -1; m_wait = 1'b0;
      m_ea = '0; m_eb = '0; m_ab_chk = 1'b1; m_mmm = '0; m_res = '0;
    end else begin
      if (exp_done) m_busy = 1'b0;
      if (m_wait && mm_done) begin
        m_a = mont(m_ea, m_eb, m_m);
        m_wait = 1'b0; m_ab_chk = 1'b0; m_age = 0;
        if (m_kind == K_CV) begin
          m_gap_done = 1'b1; m_gap = 1;
        end else if (m_ops.size() == 0) begin
          m_gap_done = 1'b1; m_gap = 3;
        end else begin
          m_gap_done = 1'b0;
          m_gap = (m_ops[0] == K_MUL) ? 1 : (m_ops[0] == K_SQ) ? 2 : 3;
        end
      end
      if (exp_issue) m_wait = 1'b1;
      if (!was_busy && start) begin
        len = (int'(exp_len) > EW) ? EW : int'(exp_len);
        m_ops.delete();
        for (int k = len - 1; k >= 0; k--) begin
          m_ops.push_back(K_SQ);
          if (in_e[k]) m_ops.push_back(K_MUL);
        end
        if (CONV) m_ops.push_back(K_CV);
        m_a = in_r; m_x = in_x; m_m = in_m; m_mmm = in_m;
        m_busy = 1'b1; m_wait = 1'b0; m_ab_chk = 1'b0; m_age = 0;
        if (m_ops.size() == 0) begin
          m_gap_done = 1'b1; m_gap = 2;
        end else begin
          m_gap_done = 1'b0;
          m_gap = (m_ops[0] == K_SQ) ? 1 : 2;
        end
      end
    end
  end

  task automatic run_case(input string name, input logic [W-1:0] xm, input logic [W-1:0] r,
                          input logic [W-1:0] m, input logic [EW-1:0] e, input logic [LW-1:0] len_in,
                          input logic [W-1:0] want, input bit hold_start);
    int len, ops, budget, cyc;
    bit seen;
    len = (int'(len_in) > EW) ? EW : int'(len_in);
    ops = len + (CONV ? 1 : 0);
    for (int k = 0; k < len; k++) ops += int'(e[k]);
    @(posedge clk); #2;
    in_x = xm; in_r = r; in_m = m; in_e = e; exp_len = len_in; start = 1'b1;
    n_pulses = 0; n_dones = 0;
    @(posedge clk); #2;
    if (!hold_start) start = 1'b0;
    budget = 30 * ops + 50;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (hold_start) begin
          in_x = rand_wide(); in_r = rand_wide(); in_m = rand_wide() | wv(1);
          in_e = rand_wide(); exp_len = LW'($urandom());
        end
        @(posedge clk); #2;
        cyc++;
      end
    end
    start = 1'b0;
    chk_b({name, " done seen"}, seen, 1'b1);
    chk({name, " result"}, result, want);
    repeat (3) @(posedge clk);
    #2;
    chk_i({name, " products"}, n_pulses, ops);
    chk_i({name, " done pulses"}, n_dones, 1);
    chk_b({name, " idle after"}, busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [EW-1:0] e1, er;
    logic [W-1:0] xp, mr, xr, want;
    int cyc, lr;
    e1 = '0;
    e1[3:0] = 4'b1011;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    chk_b("reset busy", busy, 1'b0);
    chk_b("reset mm_start", mm_start, 1'b0);
    chk_b("reset done", done, 1'b0);
    chk("reset result", result, '0);
    chk("reset mm_m", mm_m, '0);
    chk("reset mm_a", mm_a, '0);

    // literal pins for the reference arithmetic (M=13, R mod 13 = 3, x=5 -> 2)
    chk("pin pow 5^11 mod 13", powmod(wv(5), e1, 4, wv(13)), wv(8));
    chk("pin R mod 13", to_mont(wv(1), wv(13)), wv(3));
    chk("pin mont(R,1)", mont(wv(3), wv(1), wv(13)), wv(1));
    chk("pin mont(xR,xR)", mont(wv(2), wv(2), wv(13)), wv(10));

    run_case("s1", wv(2), wv(3), wv(13), e1, LW'(4), CONV ? wv(8) : wv(11), 1'b0);
    run_case("s3 len0", wv(2), wv(3), wv(13), e1, LW'(0), CONV ? wv(1) : wv(3), 1'b0);

    spur_en = 1'b1;
    run_case("s4 noisy", wv(2), wv(3), wv(13), e1, LW'(4), CONV ? wv(8) : wv(11), 1'b1);
    spur_en = 1'b0;

    // reset in the third multiply wait, multiplier answers late
    dly_min = 12; dly_max = 12;
    @(posedge clk); #2;
    in_x = wv(2); in_r = wv(3); in_m = wv(13); in_e = e1; exp_len = LW'(4); start = 1'b1;
    n_pulses = 0;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (n_pulses < 7 && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk_i("s5 reached third multiply", n_pulses, 7);
    resetn = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk_b("s5 busy", busy, 1'b0);
    chk_b("s5 done", done, 1'b0);
    chk("s5 result", result, '0);
    chk("s5 mm_m", mm_m, '0);
    chk("s5 mm_b", mm_b, '0);
    dly_min = 3; dly_max = 20;
    run_case("s5 rerun", wv(2), wv(3), wv(13), e1, LW'(4), CONV ? wv(8) : wv(11), 1'b0);

    // random small moduli; the first uses a zero-latency multiplier
    for (int t = 0; t < 4; t++) begin
      dly_min = 1; dly_max = (t == 0) ? 1 : 5;
      mr = '0;
      mr[63:0] = {1'b1, 31'($urandom()), $urandom() | 32'd1};
      xp = '0;
      xp[63:0] = {$urandom(), $urandom()};
      xp = xp % mr;
      er = rand_wide();
      lr = $urandom_range(40, 1);
      want = powmod(xp, er, lr, mr);
      if (!CONV) want = to_mont(want, mr);
      run_case("rand small", to_mont(xp, mr), to_mont(wv(1), mr), mr, er, LW'(lr), want, 1'b0);
    end

    // full-width operands, exp_len beyond the register width
    dly_min = 3; dly_max = 20;
    mr = rand_wide();
    mr[W-1] = 1'b1;
    mr[0] = 1'b1;
    xp = rand_wide() % mr;
    er = rand_wide();
    want = powmod(xp, er, EW, mr);
    if (!CONV) want = to_mont(want, mr);
    xr = to_mont(xp, mr);
    run_case("s6 wide", xr, to_mont(wv(1), mr), mr, er, LW'(2047), want, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Sequencer that computes modular exponentiation by driving one external `montgomery` multiplier through left-to-right square-and-multiply. It sits above the multiplier in the RSA datapath. It captures the operands, scans the exponent MSB-first and issues one Montgomery product at a time over a start/done handshake. It optionally performs a final conversion out of the Montgomery domain.

## Interface
Parameters:
- `WIDTH`, 1024: modulus and operand width.
- `EXP_WIDTH`, 1024: exponent register width.
- `LEN_W`, 11: width of `exp_len`; must hold the value `EXP_WIDTH`.

Ports:
- `clk`  input  1: single clock; all logic updates on its rising edge.
- `resetn`  input  1: reset, synchronous, active-low.
- `start`  input  1: one-cycle request; honoured only in IDLE.
- `in_x`  input  WIDTH: base, already in Montgomery domain (x·R mod M).
- `in_r`  input  WIDTH: R mod M, the Montgomery one.
- `in_m`  input  WIDTH: modulus, odd.
- `in_e`  input  EXP_WIDTH: exponent.
- `exp_len`  input  LEN_W: number of exponent bits to process, taken from bit `exp_len-1` down to bit 0.
- `mm_start`  output  1: one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m`  output  WIDTH: multiplier operands.
- `mm_result`  input  WIDTH+1: multiplier result; the upper bit is ignored.
- `mm_done`  input  1: one-cycle completion pulse from the multiplier.
- `result`  output  WIDTH: final value; held until the next accepted `start`.
- `done`  output  1: one-cycle pulse when `result` is valid.
- `busy`  output  1: high in every state except IDLE.

## Operation
- **Capture.** On `start` in IDLE the block registers `in_x`, `in_m`, `in_e` and `min(exp_len, EXP_WIDTH)` into bit counter `i`, and loads accumulator A with `in_r`.
- **States.**
  - IDLE → SQ_ISSUE when `start`.
  - IDLE → FINISH when `start` with `exp_len`=0.
  - SQ_ISSUE → SQ_WAIT.
  - SQ_WAIT → on `mm_done`: A ← `mm_result[WIDTH-1:0]`, then go to MUL_ISSUE if `e[i-1]`=1, else to NEXT.
  - MUL_ISSUE → MUL_WAIT.
  - MUL_WAIT → on `mm_done`: A ← result, then go to NEXT.
  - NEXT: `i` ← `i`-1, then go to SQ_ISSUE if `i`-1 ≠ 0, else FINISH.
  - FINISH → CV_ISSUE if the conversion is compiled in, else DONE.
  - CV_ISSUE → CV_WAIT.
  - CV_WAIT → on `mm_done`: A ← result, then go to DONE.
  - DONE: `result` ← A, `done`=1, then go to IDLE.
- **Operands per operation.**
  - Square: `mm_a`=`mm_b`=A.
  - Multiply: `mm_a`=A, `mm_b`=x.
  - Conversion: `mm_a`=A, `mm_b`=1.
  - `mm_m` = captured M at all times after capture.
- **Operand stability.** Operands are registered. They are stable from the cycle `mm_start` is high through the cycle `mm_done` is sampled.
- **Ignored inputs.**
  - `start` outside IDLE is ignored.
  - `mm_done` outside the *_WAIT states is ignored.
  - Exponent bits at or above `exp_len` are ignored.
- **No reduction.** The block never compares or reduces; the multiplier's result is trusted to be < M.
- **Reset mid-operation.** State returns to IDLE. `mm_start`, `done` and `busy` drop to 0 on the next edge. A late `mm_done` after reset is ignored.

## Timing
- **Reset values.** `mm_start`=0, `done`=0, `busy`=0; `result`, `mm_a`, `mm_b`, `mm_m` all 0.
- **Start to first product.** `start` sampled at edge T. `busy`=1 and `mm_start`=1 from T+1, in SQ_ISSUE.
- **Next issue.** Each `mm_done` sampled at edge D is followed by the next `mm_start` at D+1 (MUL_ISSUE) or at D+2 (through NEXT).
- **Back-to-back pulses.** `mm_start` is never high on two consecutive cycles.
- **Operation count.** With `exp_len`=L and popcount P of the used exponent bits, the block issues L+P (+1 with conversion) products.
- **Overhead.** Control overhead is at most 2 cycles per exponent bit plus 3 cycles at the end; multiplier latency is additional.
- **Completion.** `done` is high for exactly the one cycle `result` updates. `busy` falls in the cycle after `done`, when the block is back in IDLE.
- **Zero-latency multiplier.** An `mm_done` arriving in the cycle right after `mm_start` is accepted.

## Configuration
- `MONT_EXP_FINAL_CONV_EN`:
  - **Defined:** the CV_ISSUE/CV_WAIT pass runs, giving `result` = x^e mod M in normal representation.
  - **Undefined:** FINISH goes straight to DONE, giving `result` = x^e·R mod M (Montgomery domain), and the CV states are absent.

## Test plan
The bench uses a behavioural multiplier returning a·b·R⁻¹ mod m after a random 3–20 cycle delay.

1. M=13, x=5 (converted), `in_e`=0b1011, `exp_len`=4, macro defined → `result`=8, exactly 8 `mm_start` pulses, one `done` pulse.
2. Same stimulus, macro undefined → `result`=8·R mod 13, 7 `mm_start` pulses.
3. `exp_len`=0, macro defined → `result`=1 after a single conversion product; macro undefined → `result`=`in_r` with no `mm_start`.
4. `start` re-asserted every cycle while busy, plus spurious `mm_done` in SQ_ISSUE → captured operands, product count and `result` unchanged from scenario 1.
5. `resetn` low for one cycle during the 3rd MUL_WAIT, then a late `mm_done` → outputs at reset values, block stays IDLE; a new `start` with scenario 1 operands gives `result`=8.
6. `exp_len`=2047 with `EXP_WIDTH`=1024 and random 1024-bit operands → result matches the reference model computed with 1024 bits.
